// File: rtl/mem_lsu.sv
// Memory stage: store buffer drained over a req/gnt port, loads with hazard wait against
// buffered stores, sub-word alignment/extension, and a registered MEM/WB result.
module mem_lsu #(
   parameter int ADDR_W   = 32,
   parameter int SB_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_vld,
   output logic              o_rdy,
   input  logic [2:0]        i_opsel,
   input  logic              i_ren,
   input  logic              i_wen,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   input  logic [31:0]       i_res,
   input  logic [4:0]        i_rd_waddr,
   input  logic              i_rd_wen,
   output logic              o_dmem_req,
   input  logic              i_dmem_gnt,
   output logic              o_dmem_wen,
   output logic [ADDR_W-1:0] o_dmem_addr,
   output logic [31:0]       o_dmem_wdata,
   output logic [3:0]        o_dmem_mask,
   input  logic              i_dmem_rvld,
   input  logic [31:0]       i_dmem_rdata,
   output logic              o_vld,
   output logic [31:0]       o_res,
   output logic [4:0]        o_rd_waddr,
   output logic              o_rd_wen,
   output logic              o_exc,
   output logic              o_sb_empty
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_W - 2;

   typedef enum logic [1:0] {IDLE, LD_HAZ, LD_REQ, LD_WAIT} state_t;

   function automatic logic [3:0] st_mask(input logic [2:0] op, input logic [1:0] a);
      logic [3:0] m;
      case (op[1:0])
         2'b00:   m = 4'b0001 << a;
         2'b01:   m = 4'b0011 << a;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Misaligned, unsupported funct3, or both load and store requested.
   function automatic logic op_exc(input logic ren, input logic wen,
                                   input logic [2:0] op, input logic [1:0] a);
      logic e;
      if (ren && wen)        e = 1'b1;
      else if (!ren && !wen) e = 1'b0;
      else begin
         case (op)
            3'b000:  e = 1'b0;
            3'b001:  e = a[0];
            3'b010:  e = (a != 2'b00);
            3'b100:  e = wen;
            3'b101:  e = wen | a[0];
            default: e = 1'b1;
         endcase
      end
      return e;
   endfunction

   function automatic logic [31:0] ld_align(input logic [31:0] w, input logic [2:0] op,
                                            input logic [1:0] a);
      logic [31:0] s;
      logic [31:0] r;
      s = w >> {a, 3'b000};
      case (op)
         3'b000:  r = {{24{s[7]}}, s[7:0]};
         3'b100:  r = {24'd0, s[7:0]};
         3'b001:  r = {{16{s[15]}}, s[15:0]};
         3'b101:  r = {16'd0, s[15:0]};
         default: r = s;
      endcase
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   sb_count_q, sb_count_d;
   logic [PTR_W-1:0]   sb_wptr_q, sb_wptr_d;
   logic [PTR_W-1:0]   sb_rptr_q, sb_rptr_d;
   logic [SB_DEPTH-1:0] sb_vld_q, sb_vld_d;
   logic [WA_W-1:0]    sb_addr_q [SB_DEPTH];
   logic [WA_W-1:0]    sb_addr_d [SB_DEPTH];
   logic [3:0]         sb_mask_q [SB_DEPTH];
   logic [3:0]         sb_mask_d [SB_DEPTH];
   logic [31:0]        sb_data_q [SB_DEPTH];
   logic [31:0]        sb_data_d [SB_DEPTH];

   logic [ADDR_W-1:0]  ld_addr_q, ld_addr_d;
   logic [2:0]         ld_op_q, ld_op_d;
   logic [4:0]         ld_rd_waddr_q, ld_rd_waddr_d;
   logic               ld_rd_wen_q, ld_rd_wen_d;

   logic               vld_q, vld_d;
   logic [31:0]        res_q, res_d;
   logic [4:0]         rd_waddr_q, rd_waddr_d;
   logic               rd_wen_q, rd_wen_d;
   logic               exc_q, exc_d;

   logic acc, acc_exc, enq, pop, hazard, ld_issue, sb_head_vld;

   assign o_rdy       = (state_q == IDLE) && (sb_count_q != CNT_W'(SB_DEPTH));
   assign acc         = i_vld & o_rdy;
   assign acc_exc     = op_exc(i_ren, i_wen, i_opsel, i_addr[1:0]);
   assign sb_head_vld = (sb_count_q != '0);
   assign o_sb_empty  = ~sb_head_vld;
   assign enq         = acc & i_wen & ~i_ren & ~acc_exc;
   assign pop         = sb_head_vld & ~ld_issue & i_dmem_gnt;

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (sb_vld_q[i] && (sb_addr_q[i] == ld_addr_q[ADDR_W-1:2])) hazard = 1'b1;
      end
   end

   // A hazard-free load requests straight from LD_HAZ so the minimum latency holds.
   always_comb begin
      state_d  = state_q;
      ld_issue = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc && i_ren && !i_wen && !acc_exc) state_d = LD_HAZ;
         end
         LD_HAZ: begin
            if (!hazard) begin
               ld_issue = 1'b1;
               state_d  = i_dmem_gnt ? LD_WAIT : LD_REQ;
            end
         end
         LD_REQ: begin
            ld_issue = 1'b1;
            if (i_dmem_gnt) state_d = LD_WAIT;
         end
         LD_WAIT: begin
            if (i_dmem_rvld) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_dmem_req   = ld_issue | sb_head_vld;
      o_dmem_wen   = ~ld_issue & sb_head_vld;
      o_dmem_addr  = '0;
      o_dmem_mask  = 4'b0000;
      o_dmem_wdata = '0;
      if (ld_issue) begin
         o_dmem_addr = {ld_addr_q[ADDR_W-1:2], 2'b00};
         o_dmem_mask = 4'b1111;
      end else if (sb_head_vld) begin
         o_dmem_addr  = {sb_addr_q[sb_rptr_q], 2'b00};
         o_dmem_mask  = sb_mask_q[sb_rptr_q];
         o_dmem_wdata = sb_data_q[sb_rptr_q];
      end
   end

   always_comb begin
      sb_addr_d  = sb_addr_q;
      sb_mask_d  = sb_mask_q;
      sb_data_d  = sb_data_q;
      sb_vld_d   = sb_vld_q;
      sb_wptr_d  = sb_wptr_q;
      sb_rptr_d  = sb_rptr_q;
      sb_count_d = sb_count_q;
      if (pop) begin
         sb_vld_d[sb_rptr_q] = 1'b0;
         sb_rptr_d           = sb_rptr_q + PTR_W'(1);
      end
      if (enq) begin
         sb_vld_d[sb_wptr_q]  = 1'b1;
         sb_addr_d[sb_wptr_q] = i_addr[ADDR_W-1:2];
         sb_mask_d[sb_wptr_q] = st_mask(i_opsel, i_addr[1:0]);
         sb_data_d[sb_wptr_q] = i_wdata << {i_addr[1:0], 3'b000};
         sb_wptr_d            = sb_wptr_q + PTR_W'(1);
      end
      case ({enq, pop})
         2'b10:   sb_count_d = sb_count_q + CNT_W'(1);
         2'b01:   sb_count_d = sb_count_q - CNT_W'(1);
         default: sb_count_d = sb_count_q;
      endcase
   end

   always_comb begin
      ld_addr_d     = ld_addr_q;
      ld_op_d       = ld_op_q;
      ld_rd_waddr_d = ld_rd_waddr_q;
      ld_rd_wen_d   = ld_rd_wen_q;
      vld_d         = 1'b0;
      res_d         = '0;
      rd_waddr_d    = '0;
      rd_wen_d      = 1'b0;
      exc_d         = 1'b0;
      if (state_q == LD_WAIT && i_dmem_rvld) begin
         vld_d      = 1'b1;
         res_d      = ld_align(i_dmem_rdata, ld_op_q, ld_addr_q[1:0]);
         rd_waddr_d = ld_rd_waddr_q;
         rd_wen_d   = ld_rd_wen_q;
      end else if (acc) begin
         if (acc_exc) begin
            vld_d      = 1'b1;
            exc_d      = 1'b1;
            rd_waddr_d = i_rd_waddr;
         end else if (i_ren) begin
            ld_addr_d     = i_addr;
            ld_op_d       = i_opsel;
            ld_rd_waddr_d = i_rd_waddr;
            ld_rd_wen_d   = i_rd_wen;
         end else if (i_wen) begin
            vld_d      = 1'b1;
            rd_waddr_d = i_rd_waddr;
         end else begin
            vld_d      = 1'b1;
            res_d      = i_res;
            rd_waddr_d = i_rd_waddr;
            rd_wen_d   = i_rd_wen;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= IDLE;
         sb_count_q    <= '0;
         sb_wptr_q     <= '0;
         sb_rptr_q     <= '0;
         sb_vld_q      <= '0;
         ld_addr_q     <= '0;
         ld_op_q       <= '0;
         ld_rd_waddr_q <= '0;
         ld_rd_wen_q   <= 1'b0;
         vld_q         <= 1'b0;
         res_q         <= '0;
         rd_waddr_q    <= '0;
         rd_wen_q      <= 1'b0;
         exc_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         sb_count_q    <= sb_count_d;
         sb_wptr_q     <= sb_wptr_d;
         sb_rptr_q     <= sb_rptr_d;
         sb_vld_q      <= sb_vld_d;
         ld_addr_q     <= ld_addr_d;
         ld_op_q       <= ld_op_d;
         ld_rd_waddr_q <= ld_rd_waddr_d;
         ld_rd_wen_q   <= ld_rd_wen_d;
         vld_q         <= vld_d;
         res_q         <= res_d;
         rd_waddr_q    <= rd_waddr_d;
         rd_wen_q      <= rd_wen_d;
         exc_q         <= exc_d;
      end
   end

   // Entry payloads are qualified by sb_vld_q / sb_count_q, so they need no reset.
   always_ff @(posedge i_clk) begin
      sb_addr_q <= sb_addr_d;
      sb_mask_q <= sb_mask_d;
      sb_data_q <= sb_data_d;
   end

   assign o_vld      = vld_q;
   assign o_res      = res_q;
   assign o_rd_waddr = rd_waddr_q;
   assign o_rd_wen   = rd_wen_q;
   assign o_exc      = exc_q;

endmodule
